// File: rtl/jpeg_pack_pkg.sv
// Shared constants, FSM state encoding and slot record for the JPEG bit packer.
// The slot width helper lives here so the top and the selector agree on it.
package jpeg_pack_pkg;

    localparam int WORD_W     = 32;
    localparam int ACC_W      = 64;
    localparam int NUM_SLOTS  = 10;
    localparam int DC_MAX_LEN = 20;
    localparam int FILL_W     = 7;
    localparam int IDX_W      = 4;
    localparam int LEN_W      = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PACK,
        ST_PAD,
        ST_FLUSH_WAIT
    } state_e;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [WORD_W-1:0] code;
    } slot_t;

    // Mask keeping the low 'len' bits of a right-aligned code.
    function automatic logic [WORD_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        return (WORD_W'(1) << len) - WORD_W'(1);
    endfunction

endpackage

// File: rtl/pack_slot_sel.sv
// Finds the lowest-indexed slot at or after 'start' whose length is non-zero,
// so empty slots never cost a packing cycle.
module pack_slot_sel
    import jpeg_pack_pkg::*;
(
    input  slot_t            slots [NUM_SLOTS],
    input  logic [IDX_W:0]   start,
    output logic [IDX_W-1:0] idx,
    output logic             none
);

    // NOTE: every output gets a default before the loop, otherwise paths that
    // never match would leave it unassigned and infer a latch.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (((IDX_W + 1)'(i) >= start) && (slots[i].len != '0)) begin
                idx  = IDX_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/jpeg_bit_packer.sv
// Concatenates one Huffman bundle per out_valid pulse into an MSB-first stream
// and emits 32-bit words over valid/ready; flush pads the tail word with PAD_BIT.
module jpeg_bit_packer
    import jpeg_pack_pkg::*;
#(
    parameter logic PAD_BIT = 1'b1
) (
    input  logic              clk,
    input  logic              srst_n,
    input  logic              out_valid,
    input  logic [4:0]        code_length_DC,
    input  logic [19:0]       code_out_DC,
    input  logic [4:0]        code_length1,
    input  logic [31:0]       code_out1,
    input  logic [4:0]        code_length2,
    input  logic [31:0]       code_out2,
    input  logic [4:0]        code_length3,
    input  logic [31:0]       code_out3,
    input  logic [4:0]        code_length4,
    input  logic [31:0]       code_out4,
    input  logic [4:0]        code_length5,
    input  logic [31:0]       code_out5,
    input  logic [4:0]        code_length6,
    input  logic [31:0]       code_out6,
    input  logic [4:0]        code_length7,
    input  logic [31:0]       code_out7,
    input  logic [4:0]        code_length8,
    input  logic [31:0]       code_out8,
    input  logic [4:0]        code_length_table,
    input  logic [31:0]       code_out_table,
    input  logic              flush,
    output logic              in_ready,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [WORD_W-1:0] out_word,
    output logic              done,
    output logic              overflow,
    output logic [15:0]       word_count
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    slot_t              bundle_q [NUM_SLOTS];
    slot_t              bundle_d [NUM_SLOTS];
    logic [IDX_W-1:0]   cur_q, cur_d;
    logic [15:0]        word_count_q, word_count_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;

    slot_t              in_slots [NUM_SLOTS];
    logic [LEN_W-1:0]   dc_len;
    logic [LEN_W-1:0]   pad_len;
    logic [IDX_W:0]     sel_start;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_none;
    logic               pop;
    logic               app_en;
    logic [LEN_W-1:0]   app_len;
    logic [WORD_W-1:0]  app_code;

    assign word_valid = (fill_q >= FILL_W'(WORD_W));
    assign out_word   = acc_q[ACC_W-1 -: WORD_W];
    assign in_ready   = (state_q == ST_IDLE);
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign word_count = word_count_q;
    assign pop        = word_valid && word_ready;
    assign dc_len     = (code_length_DC > LEN_W'(DC_MAX_LEN)) ? LEN_W'(DC_MAX_LEN) : code_length_DC;
    assign pad_len    = LEN_W'(WORD_W - int'(fill_q));
    assign sel_start  = (state_q == ST_LOAD) ? '0 : ({1'b0, cur_q} + 1'b1);

    // Codes are masked at capture so stray high bits never reach the stream.
    always_comb begin
        in_slots[0] = '{len: dc_len,            code: WORD_W'(code_out_DC) & len_mask(dc_len)};
        in_slots[1] = '{len: code_length1,      code: code_out1 & len_mask(code_length1)};
        in_slots[2] = '{len: code_length2,      code: code_out2 & len_mask(code_length2)};
        in_slots[3] = '{len: code_length3,      code: code_out3 & len_mask(code_length3)};
        in_slots[4] = '{len: code_length4,      code: code_out4 & len_mask(code_length4)};
        in_slots[5] = '{len: code_length5,      code: code_out5 & len_mask(code_length5)};
        in_slots[6] = '{len: code_length6,      code: code_out6 & len_mask(code_length6)};
        in_slots[7] = '{len: code_length7,      code: code_out7 & len_mask(code_length7)};
        in_slots[8] = '{len: code_length8,      code: code_out8 & len_mask(code_length8)};
        in_slots[9] = '{len: code_length_table, code: code_out_table & len_mask(code_length_table)};
    end

    pack_slot_sel u_slot_sel (
        .slots (bundle_q),
        .start (sel_start),
        .idx   (sel_idx),
        .none  (sel_none)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        fill_d       = fill_q;
        bundle_d     = bundle_q;
        cur_d        = cur_q;
        word_count_d = word_count_q;
        done_d       = 1'b0;
        overflow_d   = overflow_q;
        app_en       = 1'b0;
        app_len      = '0;
        app_code     = '0;

        if (pop) begin
            acc_d        = acc_q << WORD_W;
            fill_d       = fill_q - FILL_W'(WORD_W);
            word_count_d = word_count_q + 16'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (out_valid) begin
                    bundle_d = in_slots;
                    state_d  = ST_LOAD;
                    if (flush) overflow_d = 1'b1;
                end else if (flush) begin
                    state_d = ST_PAD;
                end
            end
            ST_LOAD: begin
                if (sel_none) begin
                    state_d = ST_IDLE;
                end else begin
                    cur_d   = sel_idx;
                    state_d = ST_PACK;
                end
            end
            ST_PACK: begin
                // Appending only below one full word keeps fill + 31 within the accumulator.
                if (!word_valid) begin
                    app_en   = 1'b1;
                    app_len  = bundle_q[cur_q].len;
                    app_code = bundle_q[cur_q].code;
                    if (sel_none) state_d = ST_IDLE;
                    else          cur_d   = sel_idx;
                end
            end
            ST_PAD: begin
                if (!word_valid) begin
                    if (fill_q != '0) begin
                        app_en   = 1'b1;
                        app_len  = pad_len;
                        app_code = {WORD_W{PAD_BIT}} & len_mask(pad_len);
                    end
                    state_d = ST_FLUSH_WAIT;
                end
            end
            ST_FLUSH_WAIT: begin
                if (fill_q == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && (out_valid || flush)) overflow_d = 1'b1;

        // Left-align the new code directly below the bits already held.
        if (app_en) begin
            acc_d  = acc_q | (ACC_W'(app_code) << (FILL_W'(ACC_W) - FILL_W'(app_len) - fill_q));
            fill_d = fill_q + FILL_W'(app_len);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            fill_q       <= '0;
            cur_q        <= '0;
            word_count_q <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            // NOTE: the bundle register is cleared too, so a reset mid-bundle
            // leaves no stale codes that a later LOAD could pick up.
            for (int i = 0; i < NUM_SLOTS; i++) bundle_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            cur_q        <= cur_d;
            word_count_q <= word_count_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            for (int i = 0; i < NUM_SLOTS; i++) bundle_q[i] <= bundle_d[i];
        end
    end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Directed-vector bench for jpeg_bit_packer: each task drives one scenario and
// compares popped words and status outputs against hand-computed values.
module tb_jpeg_bit_packer;

    logic        clk = 1'b0;
    logic        srst_n = 1'b0;
    logic        out_valid = 1'b0;
    logic        flush = 1'b0;
    logic        word_ready = 1'b1;
    logic        in_ready, word_valid, done, overflow;
    logic [31:0] out_word;
    logic [15:0] word_count;
    logic [4:0]  b_len  [10];
    logic [31:0] b_code [10];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    logic [31:0] words [$];

    always #5 clk = ~clk;

    jpeg_bit_packer dut (
        .clk               (clk),
        .srst_n            (srst_n),
        .out_valid         (out_valid),
        .code_length_DC    (b_len[0]),
        .code_out_DC       (b_code[0][19:0]),
        .code_length1      (b_len[1]),
        .code_out1         (b_code[1]),
        .code_length2      (b_len[2]),
        .code_out2         (b_code[2]),
        .code_length3      (b_len[3]),
        .code_out3         (b_code[3]),
        .code_length4      (b_len[4]),
        .code_out4         (b_code[4]),
        .code_length5      (b_len[5]),
        .code_out5         (b_code[5]),
        .code_length6      (b_len[6]),
        .code_out6         (b_code[6]),
        .code_length7      (b_len[7]),
        .code_out7         (b_code[7]),
        .code_length8      (b_len[8]),
        .code_out8         (b_code[8]),
        .code_length_table (b_len[9]),
        .code_out_table    (b_code[9]),
        .flush             (flush),
        .in_ready          (in_ready),
        .word_valid        (word_valid),
        .word_ready        (word_ready),
        .out_word          (out_word),
        .done              (done),
        .overflow          (overflow),
        .word_count        (word_count)
    );

    always @(negedge clk) begin
        if (srst_n && word_valid && word_ready) words.push_back(out_word);
        if (srst_n && done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bundle();
        for (int i = 0; i < 10; i++) begin
            b_len[i]  = 5'd0;
            b_code[i] = 32'h0;
        end
    endtask

    task automatic do_reset();
        srst_n = 1'b0;
        out_valid = 1'b0;
        flush = 1'b0;
        word_ready = 1'b1;
        tick();
        tick();
        srst_n = 1'b1;
        words.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_valid();
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (!in_ready && i < 500) begin
            tick();
            i++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_idle_timeout: in_ready=%b, required 1", tag, in_ready);
        end
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        while (!done && i < 500) begin
            tick();
            i++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_done_timeout: done=%b, required 1", tag, done);
        end
        tick();
    endtask

    task automatic load_small();
        clear_bundle();
        b_len[0] = 5'd2; b_code[0] = 32'h2;
        b_len[1] = 5'd3; b_code[1] = 32'h5;
    endtask

    task automatic load_64();
        clear_bundle();
        b_len[0] = 5'd20; b_code[0] = 32'h000ABCDE;
        b_len[1] = 5'd12; b_code[1] = 32'hFFFFF123;
        b_len[2] = 5'd31; b_code[2] = 32'hFFFFFFFF;
        b_len[9] = 5'd1;  b_code[9] = 32'h00000002;
    endtask

    task automatic test_reset();
        srst_n = 1'b0;
        #3;
        n_cmp += 6;
        if (in_ready !== 1'b1)     begin n_bad++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
        if (word_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_word_valid: got %b, expected 0", word_valid); end
        if (out_word !== 32'h0)    begin n_bad++; $display("FAIL reset_out_word: got %h, expected 0", out_word); end
        if (done !== 1'b0)         begin n_bad++; $display("FAIL reset_done: got %b, expected 0", done); end
        if (overflow !== 1'b0)     begin n_bad++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
        if (word_count !== 16'd0)  begin n_bad++; $display("FAIL reset_word_count: got %0d, expected 0", word_count); end
        do_reset();
    endtask

    task automatic test_small_flush();
        do_reset();
        load_small();
        pulse_valid();
        wait_idle("small");
        pulse_flush();
        wait_done("small");
        n_cmp += 5;
        if (words.size() !== 1)     begin n_bad++; $display("FAIL small_nwords: got %0d, expected 1", words.size()); end
        if (words[0] !== 32'hAFFFFFFF) begin n_bad++; $display("FAIL small_word0: got %h, expected afffffff", words[0]); end
        if (word_count !== 16'd1)   begin n_bad++; $display("FAIL small_word_count: got %0d, expected 1", word_count); end
        if (done_cnt !== 1)         begin n_bad++; $display("FAIL small_done_cnt: got %0d, expected 1", done_cnt); end
        if (overflow !== 1'b0)      begin n_bad++; $display("FAIL small_overflow: got %b, expected 0", overflow); end
    endtask

    task automatic test_clamp_mask();
        do_reset();
        clear_bundle();
        b_len[0] = 5'd25; b_code[0] = 32'h0;
        b_len[1] = 5'd4;  b_code[1] = 32'hFFFFFFF9;
        pulse_valid();
        wait_idle("clamp");
        pulse_flush();
        wait_done("clamp");
        n_cmp += 2;
        if (words.size() !== 1)        begin n_bad++; $display("FAIL clamp_nwords: got %0d, expected 1", words.size()); end
        if (words[0] !== 32'h000009FF) begin n_bad++; $display("FAIL clamp_word0: got %h, expected 000009ff", words[0]); end
    endtask

    task automatic test_all_ones();
        int low_cycles = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            b_len[i]  = 5'd31;
            b_code[i] = 32'hFFFFFFFF;
        end
        pulse_valid();
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ones_busy: in_ready=%b, expected 0", in_ready); end
        while (!in_ready && low_cycles < 500) begin
            low_cycles++;
            tick();
        end
        n_cmp++;
        if (low_cycles < 11) begin n_bad++; $display("FAIL ones_busy_len: got %0d cycles, expected at least 11", low_cycles); end
        pulse_flush();
        wait_done("ones");
        n_cmp += 2;
        if (words.size() !== 10)   begin n_bad++; $display("FAIL ones_nwords: got %0d, expected 10", words.size()); end
        if (word_count !== 16'd10) begin n_bad++; $display("FAIL ones_word_count: got %0d, expected 10", word_count); end
        for (int i = 0; i < words.size(); i++) begin
            n_cmp++;
            if (words[i] !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL ones_word%0d: got %h, expected ffffffff", i, words[i]); end
        end
    endtask

    task automatic test_exact_64();
        do_reset();
        load_64();
        pulse_valid();
        wait_idle("exact");
        pulse_flush();
        wait_done("exact");
        n_cmp += 4;
        if (words.size() !== 2)        begin n_bad++; $display("FAIL exact_nwords: got %0d, expected 2", words.size()); end
        if (words[0] !== 32'hABCDE123) begin n_bad++; $display("FAIL exact_word0: got %h, expected abcde123", words[0]); end
        if (words[1] !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL exact_word1: got %h, expected fffffffe", words[1]); end
        if (done_cnt !== 1)            begin n_bad++; $display("FAIL exact_done_cnt: got %0d, expected 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        int bad_cycles = 0;
        do_reset();
        word_ready = 1'b0;
        load_64();
        pulse_valid();
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 20; i++) begin
            if (word_valid !== 1'b1 || out_word !== 32'hABCDE123 || in_ready !== 1'b0) bad_cycles++;
            tick();
        end
        n_cmp++;
        if (bad_cycles != 0) begin
            n_bad++;
            $display("FAIL bp_hold: %0d bad cycles (last valid=%b word=%h ready_in=%b), expected 0 (1, abcde123, 0)",
                     bad_cycles, word_valid, out_word, in_ready);
        end
        word_ready = 1'b1;
        wait_idle("bp");
        pulse_flush();
        wait_done("bp");
        n_cmp += 3;
        if (words.size() !== 2)        begin n_bad++; $display("FAIL bp_nwords: got %0d, expected 2", words.size()); end
        if (words[0] !== 32'hABCDE123) begin n_bad++; $display("FAIL bp_word0: got %h, expected abcde123", words[0]); end
        if (words[1] !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL bp_word1: got %h, expected fffffffe", words[1]); end
    endtask

    task automatic test_overflow();
        do_reset();
        load_small();
        pulse_valid();
        tick();
        clear_bundle();
        b_len[0] = 5'd8; b_code[0] = 32'h0;
        pulse_valid();
        n_cmp++;
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b, expected 1", overflow); end
        wait_idle("ovf");
        pulse_flush();
        wait_done("ovf");
        n_cmp += 3;
        if (words.size() !== 1)        begin n_bad++; $display("FAIL ovf_nwords: got %0d, expected 1", words.size()); end
        if (words[0] !== 32'hAFFFFFFF) begin n_bad++; $display("FAIL ovf_word0: got %h, expected afffffff", words[0]); end
        if (overflow !== 1'b1)         begin n_bad++; $display("FAIL ovf_sticky: got %b, expected 1", overflow); end
    endtask

    task automatic test_collision();
        do_reset();
        load_small();
        flush = 1'b1;
        pulse_valid();
        flush = 1'b0;
        n_cmp += 2;
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL coll_overflow: got %b, expected 1", overflow); end
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL coll_accept: in_ready=%b, expected 0", in_ready); end
        wait_idle("coll");
        n_cmp++;
        if (words.size() !== 0) begin n_bad++; $display("FAIL coll_no_flush: got %0d words, expected 0", words.size()); end
        pulse_flush();
        wait_done("coll");
        n_cmp++;
        if (words[0] !== 32'hAFFFFFFF) begin n_bad++; $display("FAIL coll_word0: got %h, expected afffffff", words[0]); end
    endtask

    task automatic test_reset_mid_pack();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            b_len[i]  = 5'd31;
            b_code[i] = 32'hFFFFFFFF;
        end
        pulse_valid();
        for (int i = 0; i < 6; i++) tick();
        srst_n = 1'b0;
        #1;
        n_cmp += 4;
        if (in_ready !== 1'b1)    begin n_bad++; $display("FAIL rst_mid_in_ready: got %b, expected 1", in_ready); end
        if (word_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_mid_word_valid: got %b, expected 0", word_valid); end
        if (out_word !== 32'h0)   begin n_bad++; $display("FAIL rst_mid_out_word: got %h, expected 0", out_word); end
        if (word_count !== 16'd0) begin n_bad++; $display("FAIL rst_mid_word_count: got %0d, expected 0", word_count); end
        do_reset();
        load_small();
        pulse_valid();
        wait_idle("rst_mid");
        pulse_flush();
        wait_done("rst_mid");
        n_cmp += 3;
        if (words.size() !== 1)        begin n_bad++; $display("FAIL rst_mid_nwords: got %0d, expected 1", words.size()); end
        if (words[0] !== 32'hAFFFFFFF) begin n_bad++; $display("FAIL rst_mid_word0: got %h, expected afffffff", words[0]); end
        if (word_count !== 16'd1)      begin n_bad++; $display("FAIL rst_mid_word_count2: got %0d, expected 1", word_count); end
    endtask

    initial begin
        clear_bundle();
        test_reset();
        test_small_flush();
        test_clamp_mask();
        test_all_ones();
        test_exact_64();
        test_backpressure();
        test_overflow();
        test_collision();
        test_reset_mid_pack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
